// File: rtl/debounce_defs.sv
// Shared state encodings and default sizing for the debounce_edge block.
package debounce_defs;

  localparam int unsigned DEF_CNT_W         = 16;
  localparam int unsigned DEF_STABLE_CYCLES = 4;

  localparam logic [1:0] ST_IDLE_LO = 2'b00;
  localparam logic [1:0] ST_CHK_HI  = 2'b01;
  localparam logic [1:0] ST_IDLE_HI = 2'b10;
  localparam logic [1:0] ST_CHK_LO  = 2'b11;

  typedef enum logic [1:0] {
    IDLE_LO = ST_IDLE_LO,
    CHK_HI  = ST_CHK_HI,
    IDLE_HI = ST_IDLE_HI,
    CHK_LO  = ST_CHK_LO
  } state_t;

endpackage

// File: rtl/sync_chain.sv
// Single-bit flop shift chain of DEPTH stages for metastability settling.
module sync_chain #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] ff;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff[0] <= d;
      for (int i = 1; i < int'(DEPTH); i++) begin
        ff[i] <= ff[i-1];
      end
    end
  end

  assign q = ff[DEPTH-1];

endmodule

// File: rtl/debounce_edge.sv
// Glitch-rejecting debouncer with registered level and one-cycle rise/fall pulses.
// Define DEBOUNCE_SYNC_EN to insert a 2-stage synchronizer on din (din may then be async).
module debounce_edge
  import debounce_defs::*;
#(
  parameter int unsigned CNT_W         = DEF_CNT_W,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  input  logic en,
  output logic level,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [CNT_W-1:0] LAST   = CNT_W'(STABLE_CYCLES - 1);
  localparam bit               SINGLE = (STABLE_CYCLES == 1);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             level_d, rise_d, fall_d, busy_d;
  logic             sample;

`ifdef DEBOUNCE_SYNC_EN
  sync_chain #(
    .DEPTH (2)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (din),
    .q     (sample)
  );
`else
  assign sample = din;
`endif

  // Next-state, counter and output decode; en=0 holds everything and suppresses pulses.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    level_d = level;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (en) begin
      unique case (state)
        IDLE_LO: begin
          if (sample) begin
            if (SINGLE) begin
              state_d = IDLE_HI;
              level_d = 1'b1;
              rise_d  = 1'b1;
            end else begin
              state_d = CHK_HI;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        CHK_HI: begin
          if (!sample) begin
            state_d = IDLE_LO;
            cnt_d   = '0;
          end else if (cnt == LAST) begin
            state_d = IDLE_HI;
            cnt_d   = '0;
            level_d = 1'b1;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
        IDLE_HI: begin
          if (!sample) begin
            if (SINGLE) begin
              state_d = IDLE_LO;
              level_d = 1'b0;
              fall_d  = 1'b1;
            end else begin
              state_d = CHK_LO;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        CHK_LO: begin
          if (sample) begin
            state_d = IDLE_HI;
            cnt_d   = '0;
          end else if (cnt == LAST) begin
            state_d = IDLE_LO;
            cnt_d   = '0;
            level_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end
      endcase
    end
    busy_d = (state_d == CHK_HI) || (state_d == CHK_LO);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE_LO;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      level <= level_d;
      rise  <= rise_d;
      fall  <= fall_d;
      busy  <= busy_d;
    end
  end

endmodule

// File: tb/tb_debounce_edge.sv
// Directed self-checking bench for debounce_edge (STABLE_CYCLES=4); honours DEBOUNCE_SYNC_EN.
module tb_debounce_edge;

`ifdef DEBOUNCE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst_n, din, en;
  logic level, rise, fall, busy;

  int checks   = 0;
  int failures = 0;

  debounce_edge #(
    .CNT_W         (16),
    .STABLE_CYCLES (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (din),
    .en    (en),
    .level (level),
    .rise  (rise),
    .fall  (fall),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int busy_n, rise_n, fall_n;

    rst_n = 1'b0; din = 1'b1; en = 1'b1;

    // 1: reset overrides din/en, then level rises on the 4th sampled-high edge
    for (int k = 0; k < 2; k++) begin
      tick();
      check("rst_level", level, 0);
      check("rst_rise", rise, 0);
      check("rst_fall", fall, 0);
      check("rst_busy", busy, 0);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= LAT + 3; k++) begin
      tick();
      check("s1_level_pre", level, 0);
      check("s1_rise_pre", rise, 0);
      check("s1_busy", busy, (k > LAT) ? 1 : 0);
    end
    tick();
    check("s1_level", level, 1);
    check("s1_rise", rise, 1);
    check("s1_busy_done", busy, 0);
    tick();
    check("s1_rise_once", rise, 0);

    // 4: falling qualification then alternating din never changes level
    din = 1'b0;
    for (int k = 1; k <= LAT + 3; k++) begin
      tick();
      check("s4_level_pre", level, 1);
      check("s4_fall_pre", fall, 0);
    end
    tick();
    check("s4_level", level, 0);
    check("s4_fall", fall, 1);
    check("s4_rise", rise, 0);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("s4_fall_once", fall, 0);
    end
    for (int k = 0; k < 8 + LAT; k++) begin
      din = (k < 8) ? ((k % 2 == 0) ? 1'b1 : 1'b0) : 1'b0;
      tick();
      check("s4_alt_level", level, 0);
      check("s4_alt_rise", rise, 0);
      check("s4_alt_fall", fall, 0);
    end
    din = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    check("s4_settled_busy", busy, 0);

    // 2: din held high 10 cycles: busy 3 cycles, single rise, no fall
    busy_n = 0; rise_n = 0; fall_n = 0;
    din = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      busy_n += int'(busy);
      rise_n += int'(rise);
      fall_n += int'(fall);
      if (k == LAT + 3) check("s2_level_pre", level, 0);
      if (k == LAT + 4) begin
        check("s2_level", level, 1);
        check("s2_rise_edge", rise, 1);
      end
      check("s2_no_both", int'(rise & fall), 0);
    end
    check("s2_busy_cycles", busy_n, 3);
    check("s2_rise_count", rise_n, 1);
    check("s2_fall_count", fall_n, 0);

    // 6: reset while level=1 returns to reset values with no fall pulse
    rst_n = 1'b0; din = 1'b0;
    tick();
    check("s6_level", level, 0);
    check("s6_fall", fall, 0);
    check("s6_busy", busy, 0);
    rst_n = 1'b1;
    for (int k = 0; k < LAT + 2; k++) begin
      tick();
      check("s6_post_fall", fall, 0);
      check("s6_post_level", level, 0);
    end

    // 3: three high samples are rejected as a glitch
    din = 1'b1;
    for (int k = 1; k <= LAT + 5; k++) begin
      if (k == 4) din = 1'b0;
      tick();
      check("s3_level", level, 0);
      check("s3_rise", rise, 0);
      check("s3_busy", busy, (k > LAT && k <= LAT + 3) ? 1 : 0);
    end

    // 5: en=0 freezes a check in progress; two enabled edges finish it
    din = 1'b1;
    for (int k = 0; k < LAT + 2; k++) tick();
    check("s5_busy_start", busy, 1);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("s5_frozen_level", level, 0);
      check("s5_frozen_rise", rise, 0);
      check("s5_frozen_busy", busy, 1);
    end
    en = 1'b1;
    tick();
    check("s5_level_pre", level, 0);
    tick();
    check("s5_level", level, 1);
    check("s5_rise", rise, 1);
    tick();
    check("s5_rise_once", rise, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/debounce_edge.md
Name: debounce_edge

Overview:
- Downstream consumer of the team's flip-flop synchronizer chain.
- Takes an already-synchronized single-bit input and rejects glitches shorter than STABLE_CYCLES samples.
- Produces a clean debounced level plus one-cycle rise/fall pulses for downstream control logic (button inputs, memory write strobes).
- Holds a small FSM and a saturating-compare counter.

Parameters:
- CNT_W, 16, counter width in bits; must satisfy STABLE_CYCLES <= 2^CNT_W - 1.
- STABLE_CYCLES, 4, consecutive equal samples required before the level changes; legal range >= 1.

Ports:
- clk  input  1  rising-edge clock; all state updates on posedge clk.
- rst_n  input  1  synchronous active-low reset; sampled on posedge clk.
- din  input  1  synchronized raw input (direct from the flip-flop chain).
- en  input  1  sample enable; 0 freezes the block.
- level  output  1  debounced level (registered).
- rise  output  1  one-cycle pulse when level goes 0->1 (registered).
- fall  output  1  one-cycle pulse when level goes 1->0 (registered).
- busy  output  1  high while a candidate transition is being qualified (registered, derived from state).

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a posedge):
  - state=IDLE_LO, cnt=0, level=0, rise=0, fall=0, busy=0.
  - Reset overrides en and din.
- FSM states: IDLE_LO, CHK_HI, IDLE_HI, CHK_LO.
- IDLE_LO:
  - din=1 and STABLE_CYCLES=1 -> IDLE_HI, level=1, rise=1.
  - din=1 otherwise -> CHK_HI, cnt=1.
  - din=0 -> stay.
- CHK_HI:
  - din=0 -> IDLE_LO, cnt=0, no pulse (glitch rejected).
  - din=1 and cnt==STABLE_CYCLES-1 -> IDLE_HI, cnt=0, level=1, rise=1.
  - Otherwise cnt=cnt+1.
- IDLE_HI and CHK_LO: mirror of the above with din inverted, level=0 and fall=1.
- Latency: level changes at the posedge where din has been sampled at the new value on STABLE_CYCLES consecutive enabled edges. Pulse asserts in the same cycle level changes, for exactly one cycle.
- rise and fall default to 0 every cycle and are never high together.
- busy=1 exactly in CHK_HI/CHK_LO.
- en=0: state, cnt and level hold; rise/fall forced 0. Edges with en=0 do not count as samples.
- Counter never wraps. The compare fires before cnt can exceed STABLE_CYCLES-1.
- din toggling every cycle: block stays in IDLE/CHK ping-pong; level never changes.
- Reset mid-check or while level=1: immediate return to reset values; no fall pulse emitted.

Optional Feature:
- Macro: DEBOUNCE_SYNC_EN.
- Defined: a 2-stage synchronizer (flops reset to 0 by rst_n) is inserted on din inside the block. All timing above applies to the synchronizer output, adding 2 cycles of latency. din may then be asynchronous.
- Undefined: din feeds the FSM directly and must be synchronous to clk.

Decomposition:
- Shared package/include debounce_defs:
  - State encodings IDLE_LO=2'b00, CHK_HI=2'b01, IDLE_HI=2'b10, CHK_LO=2'b11 as localparams.
  - Default CNT_W/STABLE_CYCLES constants.
- One sub-module: sync_chain. Parameter DEPTH (default 2), 1-bit flop shift chain with synchronous active-low reset. Instantiated only under DEBOUNCE_SYNC_EN.

Test Plan (STABLE_CYCLES=4, macro undefined unless stated):
1. rst_n=0 for 2 cycles with din=1, en=1 -> level=0, rise=0, fall=0, busy=0 throughout; after release, level rises on the 4th sampled-high edge.
2. din 0->1 held 10 cycles -> busy high 3 cycles, level=1 on 4th edge, rise high exactly that one cycle, fall stays 0.
3. din=1 for 3 cycles then 0 -> level stays 0, no rise, busy drops to 0 the cycle din returns low.
4. From level=1, din=0 held 6 cycles -> fall single pulse on 4th low sample, level=0; din=1,0,1,0 alternating afterwards -> no pulses.
5. During CHK_HI after 2 samples, en=0 for 5 cycles then en=1, din=1 -> level rises 2 enabled edges later; no pulses while en=0.
6. level=1, assert rst_n=0 one cycle -> level=0, fall=0. With DEBOUNCE_SYNC_EN defined, repeat scenario 2 -> level rises 2 cycles later than without the macro.
